// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the round-robin FIFO write arbiter.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int SIZE_DEF  = 8;
    localparam int NREQ_DEF  = 4;
    localparam int BURST_DEF = 4;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after last_id.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int nreq = NREQ_DEF,
    localparam int idw = id_width(nreq)
) (
    input  logic [nreq-1:0] req,
    input  logic [idw-1:0]  last_id,
    output logic            valid,
    output logic [idw-1:0]  idx
);

    logic [idw-1:0] cand;

    // Scan farthest-first so the nearest candidate is the last to win.
    always_comb begin
        valid = 1'b0;
        idx   = last_id;
        cand  = '0;
        for (int k = nreq; k >= 1; k--) begin
            cand = idw'((int'(last_id) + k) % nreq);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one FIFO write port from nreq requesters.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int size  = SIZE_DEF,
    parameter int nreq  = NREQ_DEF,
    parameter int burst = BURST_DEF,
    localparam int idw  = id_width(nreq),
    localparam int cw   = $clog2(burst) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [nreq-1:0]      req,
    input  logic [nreq*size-1:0] req_data,
    input  logic [nreq-1:0]      req_last,
    input  logic                 buf_full,
    output logic [nreq-1:0]      gnt,
    output logic [nreq-1:0]      ack,
    output logic [size-1:0]      buf_in,
    output logic                 write_en,
    output logic [idw-1:0]       active_id,
    output logic                 busy
);

    state_t         state;
    logic [cw-1:0]  wcnt;
    logic [idw-1:0] last_id;
    logic           pick_valid;
    logic [idw-1:0] pick_idx;
    logic           done;

    rr_pick #(
        .nreq(nreq)
    ) u_pick (
        .req(req),
        .last_id(last_id),
        .valid(pick_valid),
        .idx(pick_idx)
    );

    assign busy     = (state == BURST);
    assign write_en = busy & req[active_id] & ~buf_full;
    assign ack      = {nreq{write_en}} & gnt;
    assign buf_in   = busy ? req_data[int'(active_id)*size +: size] : '0;
    assign done     = (wcnt == cw'(burst - 1)) | req_last[active_id];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= '0;
            wcnt      <= '0;
            active_id <= '0;
            last_id   <= idw'(nreq - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= BURST;
                        gnt       <= nreq'(1) << pick_idx;
                        active_id <= pick_idx;
                        wcnt      <= '0;
                    end
                end
                BURST: begin
                    // A dropped request ends the grant even mid-stall.
                    if (!req[active_id]) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        last_id <= active_id;
                    end else if (write_en) begin
                        wcnt <= wcnt + cw'(1);
                        if (done) begin
                            state   <= IDLE;
                            gnt     <= '0;
                            last_id <= active_id;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random run.
module tb_fifo_wr_arbiter;

    localparam int SZ = 8;
    localparam int NR = 4;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR*SZ-1:0] req_data;
    logic [NR-1:0] req_last;
    logic          buf_full;
    logic [NR-1:0] gnt;
    logic [NR-1:0] ack;
    logic [SZ-1:0] buf_in;
    logic          write_en;
    logic [1:0]    active_id;
    logic          busy;

    int tests = 0;
    int fails = 0;

    int seq [NR];
    logic [SZ-1:0] fifo_q [$];

    // Reference model state: owner of the bus, words written, last owner.
    int m_busy, m_owner, m_cnt, m_last, m_aid;

    fifo_wr_arbiter #(.size(SZ), .nreq(NR), .burst(BL)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .req_last(req_last),
        .buf_full(buf_full),
        .gnt(gnt),
        .ack(ack),
        .buf_in(buf_in),
        .write_en(write_en),
        .active_id(active_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic set_data();
        for (int i = 0; i < NR; i++)
            req_data[i*SZ +: SZ] = SZ'(i * 64 + (seq[i] % 64));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        req_last = '0;
        buf_full = 1'b0;
        for (int i = 0; i < NR; i++) seq[i] = 0;
        set_data();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_cnt = 0; m_last = NR - 1; m_aid = 0;
    endtask

    task automatic model_step();
        int c;
        bit found;
        found = 0;
        if (m_busy == 0) begin
            for (int k = 1; k <= NR; k++) begin
                c = (m_last + k) % NR;
                if (!found && req[c]) begin
                    found = 1; m_owner = c;
                end
            end
            if (found) begin
                m_busy = 1; m_cnt = 0; m_aid = m_owner;
            end
        end else if (!req[m_owner]) begin
            m_busy = 0; m_last = m_owner;
        end else if (!buf_full) begin
            m_cnt++;
            if (m_cnt == BL || req_last[m_owner]) begin
                m_busy = 0; m_last = m_owner;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '1;
        buf_full = 1'b0;
        #1;
        tests++;
        if (gnt !== '0) begin
            fails++; $display("FAIL reset_gnt got=%b want=0000", gnt);
        end
        tests++;
        if (ack !== '0 || write_en !== 1'b0) begin
            fails++; $display("FAIL reset_wr got ack=%b we=%b want 0", ack, write_en);
        end
        tests++;
        if (busy !== 1'b0 || buf_in !== '0 || active_id !== '0) begin
            fails++;
            $display("FAIL reset_misc got busy=%b buf_in=%h id=%0d want 0",
                     busy, buf_in, active_id);
        end
    endtask

    task automatic test_rr_burst();
        logic [NR-1:0] exp_ack [15];
        exp_ack = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                    4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                    4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        do_reset();
        req = 4'b0101;
        for (int c = 0; c < 15; c++) begin
            #1;
            tests++;
            if (ack !== exp_ack[c] || write_en !== (|exp_ack[c])) begin
                fails++;
                $display("FAIL rr_burst cyc%0d got ack=%b we=%b want ack=%b",
                         c, ack, write_en, exp_ack[c]);
            end
            if (c == 5) begin
                tests++;
                if (busy !== 1'b0 || gnt !== '0) begin
                    fails++;
                    $display("FAIL rr_bubble got busy=%b gnt=%b want 0", busy, gnt);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_req_last();
        int n;
        n = 0;
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) req_last = 4'b0010;
            if (c == 3) begin req = '0; req_last = '0; end
            #1;
            if (ack[1]) n++;
            if (c == 3) begin
                tests++;
                if (busy !== 1'b0 || gnt !== '0) begin
                    fails++;
                    $display("FAIL last_exit got busy=%b gnt=%b want 0", busy, gnt);
                end
            end
            @(negedge clk);
        end
        tests++;
        if (n !== 2) begin
            fails++; $display("FAIL last_count got=%0d want=2", n);
        end
    endtask

    task automatic test_full_stall();
        int n;
        n = 0;
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            buf_full = (c >= 2 && c <= 4);
            #1;
            if (write_en) n++;
            if (c >= 2 && c <= 4) begin
                tests++;
                if (write_en !== 1'b0 || gnt !== 4'b0001 || dut.wcnt !== 3'd1) begin
                    fails++;
                    $display("FAIL stall cyc%0d got we=%b gnt=%b wcnt=%0d want 0/0001/1",
                             c, write_en, gnt, dut.wcnt);
                end
            end
            if (c == 8) begin
                tests++;
                if (busy !== 1'b0) begin
                    fails++; $display("FAIL stall_exit got busy=%b want 0", busy);
                end
            end
            @(negedge clk);
        end
        tests++;
        if (n !== 4) begin
            fails++; $display("FAIL stall_count got=%0d want=4", n);
        end
        req = '0;
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 4'b1000;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) req = '0;
            if (c == 4) req = 4'b1001;
            #1;
            if (c == 1 || c == 2) begin
                tests++;
                if (ack !== 4'b1000) begin
                    fails++; $display("FAIL drop_write cyc%0d got ack=%b want 1000", c, ack);
                end
            end
            if (c == 4) begin
                tests++;
                if (busy !== 1'b0 || gnt !== '0) begin
                    fails++;
                    $display("FAIL drop_exit got busy=%b gnt=%b want 0", busy, gnt);
                end
            end
            if (c == 5) begin
                tests++;
                if (gnt !== 4'b0001 || active_id !== 2'd0) begin
                    fails++;
                    $display("FAIL drop_next got gnt=%b id=%0d want 0001/0", gnt, active_id);
                end
            end
            @(negedge clk);
        end
        req = '0;
    endtask

    task automatic test_reset_mid_burst();
        bit seen;
        int edges;
        do_reset();
        req = 4'b0001;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (write_en !== 1'b1) begin
            fails++; $display("FAIL midrst_pre got we=%b want 1", write_en);
        end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (write_en !== 1'b0 || ack !== '0 || gnt !== '0 || busy !== 1'b0 || buf_in !== '0) begin
            fails++;
            $display("FAIL midrst_out got we=%b ack=%b gnt=%b busy=%b buf_in=%h want 0",
                     write_en, ack, gnt, busy, buf_in);
        end
        @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        edges = 0;
        while (!seen && edges < 2) begin
            @(posedge clk);
            #1;
            edges++;
            if (gnt === 4'b1000) seen = 1;
        end
        tests++;
        if (!seen || active_id !== 2'd3) begin
            fails++;
            $display("FAIL midrst_regrant got gnt=%b id=%0d after %0d edges want 1000/3",
                     gnt, active_id, edges);
        end
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_random();
        logic [NR-1:0] exp_gnt, exp_ack;
        logic [SZ-1:0] exp_buf;
        logic exp_we;
        int cnt [NR];
        do_reset();
        model_reset();
        fifo_q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (req[i]) req[i] = ($urandom_range(0, 9) != 0);
                else        req[i] = ($urandom_range(0, 9) < 3);
                req_last[i] = ($urandom_range(0, 4) == 0);
            end
            buf_full = ($urandom_range(0, 3) == 0);
            set_data();
            #1;
            exp_we  = (m_busy != 0) && req[m_owner] && !buf_full;
            exp_gnt = (m_busy != 0) ? NR'(1) << m_owner : '0;
            exp_ack = exp_we ? exp_gnt : '0;
            exp_buf = (m_busy != 0) ? req_data[m_owner*SZ +: SZ] : '0;
            tests++;
            if (gnt !== exp_gnt || busy !== (m_busy != 0) || active_id !== 2'(m_aid)) begin
                fails++;
                $display("FAIL rnd_gnt cyc%0d got gnt=%b busy=%b id=%0d want %b/%0d/%0d",
                         cyc, gnt, busy, active_id, exp_gnt, m_busy, m_aid);
            end
            tests++;
            if (write_en !== exp_we || ack !== exp_ack || buf_in !== exp_buf) begin
                fails++;
                $display("FAIL rnd_write cyc%0d got we=%b ack=%b d=%h want %b/%b/%h",
                         cyc, write_en, ack, buf_in, exp_we, exp_ack, exp_buf);
            end
            tests++;
            if ((write_en && buf_full) || !$onehot0(gnt)) begin
                fails++;
                $display("FAIL rnd_safety cyc%0d got we=%b full=%b gnt=%b", cyc,
                         write_en, buf_full, gnt);
            end
            if (write_en === 1'b1) fifo_q.push_back(buf_in);
            if (exp_we) seq[m_owner]++;
            model_step();
            @(negedge clk);
        end
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        foreach (fifo_q[j]) begin
            tests++;
            if (fifo_q[j][5:0] !== 6'(cnt[fifo_q[j][7:6]])) begin
                fails++;
                $display("FAIL rnd_order word%0d got=%h want seq %0d", j, fifo_q[j],
                         cnt[fifo_q[j][7:6]] % 64);
            end
            cnt[fifo_q[j][7:6]]++;
        end
        tests++;
        if (fifo_q.size() < 1000) begin
            fails++; $display("FAIL rnd_volume got=%0d words want >=1000", fifo_q.size());
        end
        req = '0;
    endtask

    initial begin
        rst = 1'b0;
        req = '0;
        req_last = '0;
        buf_full = 1'b0;
        req_data = '0;
        test_reset();
        test_rr_burst();
        test_req_last();
        test_full_stall();
        test_req_drop();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
